// File: rtl/tw_vgg_argmax.sv
// Argmax back-end for the ternary VGG classifier: serially scans one frame of
// signed class scores and queues {class, score, frame id} in a show-ahead FIFO.
module tw_vgg_argmax #(
  parameter  int BW         = 16,
  parameter  int NO_CLASSES = 24,
  parameter  int FIFO_DEPTH = 4,
  parameter  int FID_BW     = 16,
  localparam int CLS_BW     = $clog2(NO_CLASSES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vld_in,
  input  logic [NO_CLASSES-1:0][BW-1:0]    data_in,
  output logic                             busy,
  output logic                             vld_out,
  input  logic                             rdy_in,
  output logic [CLS_BW-1:0]                class_out,
  output logic [BW-1:0]                    score_out,
  output logic [FID_BW-1:0]                fid_out,
  output logic                             overflow
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_W = CLS_BW + BW + FID_BW;
  localparam logic [CLS_BW-1:0] LAST = CLS_BW'(NO_CLASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUSH} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [NO_CLASSES-1:0][BW-1:0]   r_data;
  logic signed [BW-1:0]            r_best;
  logic signed [BW-1:0]            w_cur;
  logic [CLS_BW-1:0]               r_idx;
  logic [CLS_BW-1:0]               r_ptr;
  logic [FID_BW-1:0]               r_tag;
  logic [FID_BW-1:0]               r_fid;
  logic                            r_overflow;

  logic [REC_W-1:0]                r_mem [FIFO_DEPTH];
  logic [REC_W-1:0]                r_last;
  logic [REC_W-1:0]                w_head;
  logic [AW-1:0]                   r_wptr;
  logic [AW-1:0]                   r_rptr;
  logic [AW:0]                     r_count;
  logic                            w_empty;
  logic                            w_full;
  logic                            w_pop;
  logic                            w_push;

  assign w_cur   = $signed(r_data[r_ptr]);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && rdy_in;
  assign w_push  = (r_state == S_PUSH) && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (vld_in) w_next = S_SCAN;
      S_SCAN:  if (r_ptr == LAST) w_next = S_PUSH;
      S_PUSH:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame capture and serial compare; strict '>' keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_best     <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_tag      <= '0;
      r_fid      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (vld_in) r_fid <= r_fid + FID_BW'(1);
      if ((vld_in && r_state != S_IDLE) || (r_state == S_PUSH && !w_push))
        r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: if (vld_in) begin
          r_data <= data_in;
          r_best <= $signed(data_in[0]);
          r_idx  <= '0;
          r_ptr  <= CLS_BW'(1);
          r_tag  <= r_fid;
        end
        S_SCAN: begin
          if (w_cur > r_best) begin
            r_best <= w_cur;
            r_idx  <= r_ptr;
          end
          r_ptr <= r_ptr + CLS_BW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_idx, r_best, r_tag};
  end

  // r_last keeps the most recently popped record visible while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_last <= r_mem[r_rptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  assign w_head    = w_empty ? r_last : r_mem[r_rptr];
  assign class_out = w_head[REC_W-1 -: CLS_BW];
  assign score_out = w_head[FID_BW +: BW];
  assign fid_out   = w_head[FID_BW-1:0];
  assign vld_out   = !w_empty;
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tw_vgg_argmax.sv
// Directed bench for tw_vgg_argmax: stimulus pushes expected records into a
// scoreboard queue, a negedge monitor pops and compares every handshake.
module tb_tw_vgg_argmax;

  localparam int BW = 16;
  localparam int NC = 24;
  localparam int FD = 4;
  localparam int FB = 16;
  localparam int CB = $clog2(NC);

  typedef logic [NC-1:0][BW-1:0] frame_t;
  typedef struct packed {
    logic [CB-1:0] cls;
    logic [BW-1:0] score;
    logic [FB-1:0] fid;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld_in;
  frame_t        data_in;
  logic          busy;
  logic          vld_out;
  logic          rdy_in;
  logic [CB-1:0] class_out;
  logic [BW-1:0] score_out;
  logic [FB-1:0] fid_out;
  logic          overflow;

  rec_t expQ[$];
  rec_t monExp;
  int   checkCount = 0;
  int   passCount  = 0;
  int   popCount   = 0;

  tw_vgg_argmax #(.BW(BW), .NO_CLASSES(NC), .FIFO_DEPTH(FD), .FID_BW(FB)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .busy(busy),
    .vld_out(vld_out), .rdy_in(rdy_in), .class_out(class_out),
    .score_out(score_out), .fid_out(fid_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: every accepted head record must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && vld_out && rdy_in) begin
      popCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_record: got fid 0x%0h class 0x%0h, expected none",
                 fid_out, class_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("rec_class", 32'(class_out), 32'(monExp.cls));
        checkOutput("rec_score", 32'(score_out), 32'(monExp.score));
        checkOutput("rec_fid",   32'(fid_out),   32'(monExp.fid));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst    = 1'b1;
    vld_in = 1'b0;
    rdy_in = 1'b0;
    expQ.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Pulses vld_in for the current cycle, then scrambles data_in after capture.
  task automatic applyStimulus(input frame_t f, input bit expectAccept, input rec_t e);
    vld_in  = 1'b1;
    data_in = f;
    if (expectAccept) expQ.push_back(e);
    tick(1);
    vld_in  = 1'b0;
    data_in = ~f;
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      tick(1);
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  function automatic rec_t mkRec(input int cls, input logic [BW-1:0] score, input int fid);
    rec_t r;
    r.cls   = CB'(cls);
    r.score = score;
    r.fid   = FB'(fid);
    return r;
  endfunction

  function automatic frame_t peakFrame(input int k);
    frame_t f = '0;
    f[k] = BW'(100 + k);
    return f;
  endfunction

  function automatic frame_t rampFrame();
    frame_t f;
    for (int i = 0; i < NC; i++) f[i] = BW'(i - 30);
    return f;
  endfunction

  function automatic frame_t tieFrame();
    frame_t f = '0;
    f[0]  = 16'h8000;
    f[5]  = 16'h7FFF;
    f[17] = 16'h7FFF;
    return f;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   p0;
    rec_t none;
    none    = '0;
    rst     = 1'b1;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    data_in = '0;
    #12;
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_vld_out",   32'(vld_out),   32'd0);
    checkOutput("rst_class",     32'(class_out), 32'd0);
    checkOutput("rst_score",     32'(score_out), 32'd0);
    checkOutput("rst_fid",       32'(fid_out),   32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);

    $display("[TB] single frame latency");
    rdy_in = 1'b1;
    applyStimulus(rampFrame(), 1'b1, mkRec(23, 16'hFFF9, 0));
    checkOutput("busy_cycle1", 32'(busy), 32'd1);
    lat = 1;
    while (!vld_out && lat < 60) begin
      tick(1);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd25);
    tick(1);
    checkOutput("vld_one_cycle", 32'(vld_out), 32'd0);
    checkOutput("hold_class", 32'(class_out), 32'd23);

    $display("[TB] ties and signed compare");
    applyStimulus(tieFrame(), 1'b1, mkRec(5, 16'h7FFF, 1));
    waitDrain("tie_drain", 60);

    $display("[TB] back-pressure and full FIFO");
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(peakFrame(k + 1), 1'b1, mkRec(k + 1, 16'(101 + k), k));
      tick(29);
    end
    checkOutput("full_no_overflow", 32'(overflow),  32'd0);
    checkOutput("full_head_fid",    32'(fid_out),   32'd0);
    checkOutput("full_head_class",  32'(class_out), 32'd1);
    applyStimulus(peakFrame(5), 1'b0, none);
    tick(29);
    checkOutput("drop_overflow", 32'(overflow), 32'd1);
    p0     = popCount;
    rdy_in = 1'b1;
    waitDrain("bp_drain", 20);
    tick(2);
    checkOutput("bp_pops",     32'(popCount - p0), 32'd4);
    checkOutput("bp_empty",    32'(vld_out),       32'd0);
    checkOutput("bp_hold_fid", 32'(fid_out),       32'd3);

    $display("[TB] busy collision");
    doReset();
    rdy_in = 1'b1;
    applyStimulus(peakFrame(2), 1'b1, mkRec(2, 16'd102, 0));
    tick(9);
    applyStimulus(peakFrame(9), 1'b0, none);
    tick(15);
    applyStimulus(peakFrame(7), 1'b1, mkRec(7, 16'd107, 2));
    waitDrain("collision_drain", 40);
    checkOutput("collision_overflow", 32'(overflow), 32'd1);

    $display("[TB] push and pop while full");
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(peakFrame(k + 10), 1'b1, mkRec(k + 10, 16'(110 + k), k));
      tick(29);
    end
    p0 = popCount;
    applyStimulus(peakFrame(20), 1'b1, mkRec(20, 16'd120, 4));
    tick(23);
    checkOutput("push_cycle_busy", 32'(busy), 32'd1);
    rdy_in = 1'b1;
    tick(1);
    rdy_in = 1'b0;
    tick(2);
    checkOutput("pushpop_no_overflow", 32'(overflow),       32'd0);
    checkOutput("pushpop_one_pop",     32'(popCount - p0),  32'd1);
    checkOutput("pushpop_still_full",  32'(vld_out),        32'd1);
    p0     = popCount;
    rdy_in = 1'b1;
    waitDrain("pushpop_drain", 20);
    tick(2);
    checkOutput("pushpop_occupancy", 32'(popCount - p0), 32'd4);

    $display("[TB] reset during scan");
    doReset();
    applyStimulus(peakFrame(3), 1'b1, mkRec(3, 16'd103, 0));
    tick(29);
    applyStimulus(peakFrame(4), 1'b1, mkRec(4, 16'd104, 1));
    tick(29);
    applyStimulus(peakFrame(6), 1'b0, none);
    tick(11);
    checkOutput("pre_rst_vld",   32'(vld_out),   32'd1);
    checkOutput("pre_rst_class", 32'(class_out), 32'd3);
    checkOutput("pre_rst_busy",  32'(busy),      32'd1);
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("mid_rst_busy",     32'(busy),      32'd0);
    checkOutput("mid_rst_vld",      32'(vld_out),   32'd0);
    checkOutput("mid_rst_class",    32'(class_out), 32'd0);
    checkOutput("mid_rst_score",    32'(score_out), 32'd0);
    checkOutput("mid_rst_fid",      32'(fid_out),   32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    rdy_in = 1'b1;
    applyStimulus(peakFrame(8), 1'b1, mkRec(8, 16'd108, 0));
    waitDrain("post_rst_drain", 40);
    tick(3);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
